// File: rtl/ct_spsram_128x104_ctrl.sv
// ct_spsram_128x104_ctrl: request/response front end for a 128x104 single-port SRAM.
// Reads have one cycle of latency. A one-entry hold register parks read data while
// the consumer stalls. Writes are masked per 26-bit lane.
// Optional build macro CT_SPSRAM_INIT_EN: when defined, the array is swept to zero
// after reset and on init_req. When undefined, the block serves requests right after reset.
module ct_spsram_128x104_ctrl (
  input  logic         cpuclk,
  input  logic         cpurst_b,
  input  logic         req_vld,
  output logic         req_rdy,
  input  logic         req_wr,
  input  logic [6:0]   req_addr,
  input  logic [103:0] req_wdata,
  input  logic [3:0]   req_lane_wen,
  output logic         rsp_vld,
  input  logic         rsp_rdy,
  output logic [103:0] rsp_data,
  input  logic         init_req,
  output logic         init_done,
  output logic [6:0]   sram_a,
  output logic         sram_cen,
  output logic         sram_gwen,
  output logic [103:0] sram_wen,
  output logic [103:0] sram_d,
  input  logic [103:0] sram_q
);

  localparam int LANES  = 4;
  localparam int LANE_W = 26;

  typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_e;

`ifdef CT_SPSRAM_INIT_EN
  localparam state_e RST_STATE = ST_INIT;
`else
  localparam state_e RST_STATE = ST_READY;
  logic unused_init_req;
  assign unused_init_req = init_req;
`endif

  state_e         state_q, state_d;
  logic [6:0]     init_cnt_q, init_cnt_d;
  logic           init_done_q, init_done_d;
  logic           rd_pend_q, rd_pend_d;
  logic           hold_full_q, hold_full_d;
  logic [103:0]   hold_q, hold_d;
  logic           accept;
  logic           sweep_act;

  // The sweep must stay off the SRAM while reset is held, hence the reset gate.
  assign sweep_act = cpurst_b && (state_q == ST_INIT);
  assign req_rdy   = init_done_q && (state_q == ST_READY) && !hold_full_q &&
                     !(rd_pend_q && !rsp_rdy);
  assign accept    = req_vld && req_rdy;
  assign init_done = init_done_q;

  // Response mux: held data takes priority, otherwise the SRAM output one cycle after a read.
  always_comb begin
    rsp_vld  = hold_full_q || rd_pend_q;
    rsp_data = '0;
    if (hold_full_q)    rsp_data = hold_q;
    else if (rd_pend_q) rsp_data = sram_q;
  end

  // SRAM drive: the clearing sweep owns the port in INIT; accepted requests go out in the same cycle.
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (sweep_act) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = init_cnt_q;
    end else if (accept) begin
      sram_cen = 1'b0;
      sram_a   = req_addr;
      if (req_wr) begin
        sram_gwen = 1'b0;
        sram_d    = req_wdata;
        for (int k = 0; k < LANES; k++)
          sram_wen[LANE_W*k +: LANE_W] = {LANE_W{!req_lane_wen[k]}};
      end
    end
  end

  // Next state: read pipeline, hold register, and the INIT/READY sequencing.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    rd_pend_d   = accept && !req_wr;
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    if (rd_pend_q && !rsp_rdy) begin
      hold_full_d = 1'b1;
      hold_d      = sram_q;
    end else if (hold_full_q && rsp_rdy) begin
      hold_full_d = 1'b0;
    end
`ifdef CT_SPSRAM_INIT_EN
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 7'd1;
        if (init_cnt_q == 7'd127) begin
          state_d     = ST_READY;
          init_done_d = 1'b1;
        end
      end
      default: begin
        if (init_req) begin
          // Re-clear: any outstanding read response is discarded.
          state_d     = ST_INIT;
          init_cnt_d  = '0;
          init_done_d = 1'b0;
          rd_pend_d   = 1'b0;
          hold_full_d = 1'b0;
        end
      end
    endcase
`else
    init_done_d = 1'b1;
`endif
  end

  // All state registers, async active-low reset.
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q     <= RST_STATE;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      hold_full_q <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      rd_pend_q   <= rd_pend_d;
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
    end
  end

endmodule

// File: tb/tb_ct_spsram_128x104_ctrl.sv
// Directed bench for ct_spsram_128x104_ctrl with a behavioral 128x104 SRAM.
// Builds with or without CT_SPSRAM_INIT_EN; expectations follow the macro.
module tb_ct_spsram_128x104_ctrl;

  logic         cpuclk = 1'b0;
  logic         cpurst_b;
  logic         req_vld, req_rdy, req_wr;
  logic [6:0]   req_addr;
  logic [103:0] req_wdata;
  logic [3:0]   req_lane_wen;
  logic         rsp_vld, rsp_rdy;
  logic [103:0] rsp_data;
  logic         init_req, init_done;
  logic [6:0]   sram_a;
  logic         sram_cen, sram_gwen;
  logic [103:0] sram_wen, sram_d, sram_q;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [103:0] PAT     = 104'h0DEC_AF00_1234_5678_9ABC_DEF0_11;
  localparam logic [103:0] D7F     = 104'h0123_4567_89AB_CDEF_0123_4567_89;
  localparam logic [103:0] ALLA    = {26{4'hA}};
  localparam logic [103:0] WEN0101 = {26'h3FFFFFF, 26'h0, 26'h3FFFFFF, 26'h0};
  localparam logic [103:0] EXP10   = {26'h0, 26'h2AAAAAA, 26'h0, 26'h2AAAAAA};
  localparam logic [103:0] JUNK    = {13{8'hEE}};
`ifdef CT_SPSRAM_INIT_EN
  localparam logic [103:0] EXP45 = '0;
`else
  localparam logic [103:0] EXP45 = PAT;
`endif

  always #5 cpuclk = ~cpuclk;

  ct_spsram_128x104_ctrl dut (
    .cpuclk(cpuclk), .cpurst_b(cpurst_b),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_lane_wen(req_lane_wen),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
    .init_req(init_req), .init_done(init_done),
    .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
    .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q)
  );

  // SRAM model: preloaded while reset is held; output goes to junk on non-read cycles
  // so a stale sram_q cannot stand in for the hold register.
  logic [103:0] mem [128];
  always @(posedge cpuclk) begin
    if (!cpurst_b) begin
      for (int i = 0; i < 128; i++) mem[i] <= '0;
      mem[7'h45] <= PAT;
      sram_q     <= JUNK;
    end else if (!sram_cen && sram_gwen) begin
      sram_q <= mem[sram_a];
    end else begin
      if (!sram_cen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      sram_q <= JUNK;
    end
  end

  task automatic chk(input string tag, input logic [103:0] act, input logic [103:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpuclk);
    #1;
  endtask

  task automatic do_write(input logic [6:0] a, input logic [103:0] d, input logic [3:0] lw,
                          input logic [103:0] exp_wen);
    req_vld = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d; req_lane_wen = lw;
    #1;
    chk("wr_rdy",  104'(req_rdy),   104'(1'b1));
    chk("wr_cen",  104'(sram_cen),  104'(1'b0));
    chk("wr_gwen", 104'(sram_gwen), 104'(1'b0));
    chk("wr_a",    104'(sram_a),    104'(a));
    chk("wr_d",    sram_d,          d);
    chk("wr_wen",  sram_wen,        exp_wen);
    tick();
    req_vld = 1'b0;
  endtask

  task automatic do_read(input logic [6:0] a, input logic [103:0] exp);
    req_vld = 1'b1; req_wr = 1'b0; req_addr = a; rsp_rdy = 1'b1;
    #1;
    chk("rd_rdy",      104'(req_rdy),   104'(1'b1));
    chk("rd_cen",      104'(sram_cen),  104'(1'b0));
    chk("rd_gwen",     104'(sram_gwen), 104'(1'b1));
    chk("rd_a",        104'(sram_a),    104'(a));
    chk("rd_vld_early",104'(rsp_vld),   104'(1'b0));
    tick();
    req_vld = 1'b0;
    chk("rd_vld",  104'(rsp_vld), 104'(1'b1));
    chk("rd_data", rsp_data,      exp);
    tick();
    chk("rd_vld_after",  104'(rsp_vld), 104'(1'b0));
    chk("rd_data_idle",  rsp_data,      '0);
  endtask

  initial begin
    cpurst_b = 1'b0; init_req = 1'b0; rsp_rdy = 1'b1;
    req_vld = 1'b1; req_wr = 1'b1; req_addr = 7'h33; req_wdata = '1; req_lane_wen = 4'hF;
    #12;
    // Outputs held quiet during reset even with a request presented.
    chk("rst_rdy",   104'(req_rdy),   104'(1'b0));
    chk("rst_vld",   104'(rsp_vld),   104'(1'b0));
    chk("rst_data",  rsp_data,        '0);
    chk("rst_done",  104'(init_done), 104'(1'b0));
    chk("rst_cen",   104'(sram_cen),  104'(1'b1));
    chk("rst_gwen",  104'(sram_gwen), 104'(1'b1));
    chk("rst_wen",   sram_wen,        '1);
    chk("rst_a",     104'(sram_a),    '0);
    chk("rst_d",     sram_d,          '0);
    tick(); tick();
    cpurst_b = 1'b1; req_vld = 1'b0;
    #1;
`ifdef CT_SPSRAM_INIT_EN
    for (int i = 0; i < 128; i++) begin
      chk("sweep_a",    104'(sram_a),    104'(7'(i)));
      chk("sweep_cen",  104'(sram_cen),  104'(1'b0));
      chk("sweep_done", 104'(init_done), 104'(1'b0));
      chk("sweep_rdy",  104'(req_rdy),   104'(1'b0));
      tick();
    end
    chk("post_sweep_done", 104'(init_done), 104'(1'b1));
`else
    chk("pre_done", 104'(init_done), 104'(1'b0));
    tick();
    chk("done_1cyc", 104'(init_done), 104'(1'b1));
    chk("no_sweep",  104'(sram_cen),  104'(1'b1));
`endif
    do_read(7'h45, EXP45);

    // Lane-masked write, then a write with no lanes enabled must leave data untouched.
    do_write(7'h10, ALLA, 4'b0101, WEN0101);
    do_read(7'h10, EXP10);
    do_write(7'h10, '1, 4'b0000, '1);
    do_read(7'h10, EXP10);

    // Write then read the same address back-to-back.
    do_write(7'h7F, D7F, 4'hF, '0);
    do_read(7'h7F, D7F);

    // Consumer stalls for three cycles; a competing request must not be accepted.
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 7'h7F; rsp_rdy = 1'b0;
    tick();
    req_addr = 7'h10;
    for (int s = 0; s < 3; s++) begin
      chk("stall_vld",  104'(rsp_vld),  104'(1'b1));
      chk("stall_data", rsp_data,       D7F);
      chk("stall_rdy",  104'(req_rdy),  104'(1'b0));
      chk("stall_cen",  104'(sram_cen), 104'(1'b1));
      tick();
    end
    rsp_rdy = 1'b1;
    #1;
    chk("take_vld",  104'(rsp_vld), 104'(1'b1));
    chk("take_data", rsp_data,      D7F);
    chk("take_rdy",  104'(req_rdy), 104'(1'b0));
    req_vld = 1'b0;
    tick();
    chk("taken_vld", 104'(rsp_vld), 104'(1'b0));
    chk("taken_rdy", 104'(req_rdy), 104'(1'b1));

    // init_req while a response is parked in the hold register.
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 7'h10; rsp_rdy = 1'b0;
    tick();
    req_vld = 1'b0;
    tick();
    chk("held_vld",  104'(rsp_vld), 104'(1'b1));
    chk("held_data", rsp_data,      EXP10);
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
`ifdef CT_SPSRAM_INIT_EN
    chk("drop_vld",  104'(rsp_vld), 104'(1'b0));
    chk("drop_data", rsp_data,      '0);
    for (int i = 0; i < 128; i++) begin
      chk("resweep_a",    104'(sram_a),    104'(7'(i)));
      chk("resweep_done", 104'(init_done), 104'(1'b0));
      tick();
    end
    rsp_rdy = 1'b1;
    chk("resweep_end", 104'(init_done), 104'(1'b1));
    do_read(7'h10, '0);
    do_read(7'h7F, '0);
    do_read(7'h45, '0);
`else
    chk("ign_vld",  104'(rsp_vld),   104'(1'b1));
    chk("ign_data", rsp_data,        EXP10);
    chk("ign_done", 104'(init_done), 104'(1'b1));
    rsp_rdy = 1'b1;
    tick();
    chk("ign_taken", 104'(rsp_vld), 104'(1'b0));
    do_read(7'h10, EXP10);
    do_read(7'h45, PAT);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
